// File: rtl/fb_access_sched.sv
// fb_access_sched: single-port scheduler for the 128x128x12 framebuffer BRAM.
// Scanout reads win, then the clear engine, then host writes; one access per clock.
module fb_access_sched #(
  parameter int ROW_W  = 7,
  parameter int COL_W  = 7,
  parameter int DATA_W = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     scan_req,
  input  logic [ROW_W-1:0]         scan_row,
  input  logic [COL_W-1:0]         scan_col,
  output logic [DATA_W-1:0]        scan_data,
  output logic                     scan_valid,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ROW_W-1:0]         wr_row,
  input  logic [COL_W-1:0]         wr_col,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_start,
  input  logic [DATA_W-1:0]        clr_color,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic [ROW_W+COL_W-1:0]   mem_addr,
  output logic                     mem_re,
  output logic                     mem_we,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int AW = ROW_W + COL_W;
  localparam logic [AW-1:0] LAST = '1;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   color_q, color_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                re_q, re_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                tag_q;
  logic                svalid_q;
  logic [DATA_W-1:0]   sdata_q;

  logic rd_gnt, cl_gnt, wr_gnt;

  assign clr_busy = (state_q == CLEAR);
  assign wr_ready = reset && (state_q == IDLE)
                    && !scan_req && !clr_start;

  assign rd_gnt = scan_req;
  assign cl_gnt = !scan_req && clr_busy;
  assign wr_gnt = wr_valid && wr_ready;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    color_d   = color_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    re_d      = 1'b0;
    we_d      = 1'b0;
    done_d    = 1'b0;
    unique case (1'b1)
      rd_gnt: begin
        re_d   = 1'b1;
        addr_d = {scan_row, scan_col};
      end
      cl_gnt: begin
        we_d      = 1'b1;
        addr_d    = clr_cnt_q;
        wdata_d   = color_q;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      wr_gnt: begin
        we_d    = 1'b1;
        addr_d  = {wr_row, wr_col};
        wdata_d = wr_data;
      end
      default: ;
    endcase
    // A scan read may coexist with the start; the first fill write waits.
    if (state_q == IDLE && clr_start) begin
      state_d   = CLEAR;
      clr_cnt_d = '0;
      color_d   = clr_color;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
      color_q   <= '0;
      addr_q    <= '0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      tag_q     <= 1'b0;
      svalid_q  <= 1'b0;
      sdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      color_q   <= color_d;
      addr_q    <= addr_d;
      re_q      <= re_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      tag_q     <= re_q;
      svalid_q  <= tag_q;
      if (tag_q) sdata_q <= mem_rdata;
    end
  end

  assign mem_addr   = addr_q;
  assign mem_re     = re_q;
  assign mem_we     = we_q;
  assign mem_wdata  = wdata_q;
  assign clr_done   = done_q;
  assign scan_valid = svalid_q;
  assign scan_data  = sdata_q;

endmodule

// File: tb/tb_fb_access_sched.sv
// tb_fb_access_sched: random + directed bench for fb_access_sched.
// A framebuffer-level reference model predicts every bus cycle and scan return.
module tb_fb_access_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        scan_req = 1'b0;
  logic [6:0]  scan_row = '0;
  logic [6:0]  scan_col = '0;
  logic [11:0] scan_data;
  logic        scan_valid;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [6:0]  wr_row = '0;
  logic [6:0]  wr_col = '0;
  logic [11:0] wr_data = '0;
  logic        clr_start = 1'b0;
  logic [11:0] clr_color = '0;
  logic        clr_busy;
  logic        clr_done;
  logic [13:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;

  always #5 clk = ~clk;

  fb_access_sched dut (
    .clk        (clk),
    .reset      (reset),
    .scan_req   (scan_req),
    .scan_row   (scan_row),
    .scan_col   (scan_col),
    .scan_data  (scan_data),
    .scan_valid (scan_valid),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_data    (wr_data),
    .clr_start  (clr_start),
    .clr_color  (clr_color),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Framebuffer BRAM: writes and reads both take effect at the sampling edge.
  logic [11:0] ram [16384];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] = mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  int tests = 0;
  int errs  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: picture contents plus the expected bus activity.
  logic [11:0] fb [16384];
  bit          m_clr = 1'b0;
  int          m_next = 0;
  logic [11:0] m_color = '0;
  bit          m_acc = 1'b0;
  bit          e_re = 1'b0, e_we = 1'b0, e_done = 1'b0, e_sv = 1'b0;
  logic [13:0] e_addr = '0;
  logic [11:0] e_wd = '0, e_sd = '0;
  bit          h1 = 1'b0, h2 = 1'b0;
  logic [11:0] sq [$];
  bit          u_we = 1'b0;
  logic [13:0] u_addr = '0;
  logic [11:0] u_old = '0;

  function automatic void mw(input logic [13:0] a, input logic [11:0] d);
    u_we   = 1'b1;
    u_addr = a;
    u_old  = fb[a];
    fb[a]  = d;
    e_we   = 1'b1;
    e_addr = a;
    e_wd   = d;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      // A write issued but not yet committed never reaches the RAM.
      if (u_we) fb[u_addr] = u_old;
      u_we = 1'b0; m_clr = 1'b0; m_next = 0; m_acc = 1'b0;
      e_re = 1'b0; e_we = 1'b0; e_done = 1'b0; e_sv = 1'b0;
      e_addr = '0; e_wd = '0; e_sd = '0;
      h1 = 1'b0; h2 = 1'b0;
      sq.delete();
    end else begin
      bit was_clr;
      was_clr = m_clr;
      e_re = 1'b0; e_we = 1'b0; e_done = 1'b0;
      u_we = 1'b0; m_acc = 1'b0;
      e_sv = h2;
      if (h2) e_sd = sq.pop_front();
      h2 = h1;
      h1 = scan_req;
      if (scan_req) begin
        e_re   = 1'b1;
        e_addr = {scan_row, scan_col};
        sq.push_back(fb[e_addr]);
      end else if (m_clr) begin
        mw(m_next[13:0], m_color);
        if (m_next == 16383) begin
          e_done = 1'b1;
          m_clr  = 1'b0;
        end
        m_next++;
      end else if (wr_valid && !clr_start) begin
        mw({wr_row, wr_col}, wr_data);
        m_acc = 1'b1;
      end
      if (!was_clr && clr_start) begin
        m_clr   = 1'b1;
        m_next  = 0;
        m_color = clr_color;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (reset) begin
      chk("mem_re", 32'(mem_re), 32'(e_re));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
      chk("clr_done", 32'(clr_done), 32'(e_done));
      chk("clr_busy", 32'(clr_busy), 32'(m_clr));
      chk("scan_valid", 32'(scan_valid), 32'(e_sv));
      if (e_sv) chk("scan_data", 32'(scan_data), 32'(e_sd));
    end
  end

  always @(negedge clk) begin
    #1;
    chk("wr_ready", 32'(wr_ready),
        32'(reset && !m_clr && !scan_req && !clr_start));
  end

  int nw, nd, nsv, nrd, cyc;

  task automatic step();
    @(posedge clk);
    #2;
    nw  += int'(mem_we);
    nd  += int'(clr_done);
    nsv += int'(scan_valid);
    nrd += int'(mem_re);
    @(negedge clk);
  endtask

  task automatic rnd_scan(input int pct);
    scan_req = ($urandom_range(99) < pct);
    scan_row = 7'($urandom);
    scan_col = 7'($urandom);
  endtask

  task automatic rnd_host();
    if (!wr_valid || m_acc) begin
      wr_valid = 1'($urandom_range(1));
      wr_row   = 7'($urandom);
      wr_col   = 7'($urandom);
      wr_data  = 12'($urandom);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_scan_data"}, 32'(scan_data), 32'd0);
    chk({tag, "_scan_valid"}, 32'(scan_valid), 32'd0);
    chk({tag, "_clr_busy"}, 32'(clr_busy), 32'd0);
    chk({tag, "_clr_done"}, 32'(clr_done), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_re"}, 32'(mem_re), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      ram[i] = '0;
      fb[i]  = '0;
    end
    nw = 0; nd = 0; nsv = 0; nrd = 0; cyc = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("por");
    reset = 1'b1;

    // Preload 0x105 through the host port, then read it back.
    wr_valid = 1'b1; wr_row = 7'd2; wr_col = 7'd5; wr_data = 12'hABC;
    step();
    wr_valid = 1'b0;
    scan_req = 1'b1; scan_row = 7'd2; scan_col = 7'd5;
    step();
    chk("rd_addr", 32'(mem_addr), 32'h105);
    chk("rd_re", 32'(mem_re), 32'd1);
    scan_req = 1'b0;
    step();
    chk("rd_valid_early", 32'(scan_valid), 32'd0);
    step();
    chk("rd_valid", 32'(scan_valid), 32'd1);
    chk("rd_data", 32'(scan_data), 32'hABC);

    // Host write blocked by scanout, then accepted.
    scan_req = 1'b1; scan_row = '0; scan_col = '0;
    wr_valid = 1'b1; wr_row = 7'd127; wr_col = 7'd127; wr_data = 12'h0F0;
    #1 chk("wr_ready_scan", 32'(wr_ready), 32'd0);
    step();
    chk("wr_blocked_we", 32'(mem_we), 32'd0);
    scan_req = 1'b0;
    #1 chk("wr_ready_free", 32'(wr_ready), 32'd1);
    step();
    chk("wr_we", 32'(mem_we), 32'd1);
    chk("wr_addr", 32'(mem_addr), 32'h3FFF);
    chk("wr_wdata", 32'(mem_wdata), 32'h0F0);
    wr_valid = 1'b0;

    // Random scan/host traffic.
    for (int i = 0; i < 1500; i++) begin
      rnd_scan(40);
      rnd_host();
      step();
    end
    scan_req = 1'b0; wr_valid = 1'b0;
    repeat (3) step();

    // Clear on an idle bus; a second start midway must be ignored.
    clr_color = 12'h00F; clr_start = 1'b1;
    wr_valid = 1'b1; wr_row = 7'd5; wr_col = 7'd5; wr_data = 12'h555;
    step();
    clr_start = 1'b0;
    nw = 0; nd = 0; cyc = 0;
    while (nd == 0 && cyc < 20000) begin
      if (cyc == 500) begin
        clr_start = 1'b1; clr_color = 12'h777;
      end else begin
        clr_start = 1'b0;
      end
      step();
      cyc++;
    end
    chk("clr_cycles", 32'(cyc), 32'd16384);
    chk("clr_writes", 32'(nw), 32'd16384);
    step();
    wr_valid = 1'b0;
    chk("clr_busy_after", 32'(clr_busy), 32'd0);
    chk("clr_done_once", 32'(nd), 32'd1);
    repeat (2) step();

    // Clear interleaved with 50% scanout.
    clr_color = 12'h3C3; clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    nw = 0; nd = 0; nsv = 0; nrd = 0; cyc = 0;
    while (nd == 0 && cyc < 40000) begin
      scan_req = (cyc % 2 == 0);
      scan_row = 7'($urandom);
      scan_col = 7'($urandom);
      step();
      cyc++;
    end
    scan_req = 1'b0;
    repeat (3) step();
    chk("ilv_cycles", 32'(cyc), 32'd32768);
    chk("ilv_writes", 32'(nw), 32'd16384);
    chk("ilv_returns", 32'(nsv), 32'(nrd));
    chk("ilv_reads", 32'(nrd), 32'd16384);

    // Reset in the middle of a clear with scan traffic in flight.
    clr_color = 12'hF00; clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    nw = 0; cyc = 0;
    while (nw < 1000 && cyc < 5000) begin
      rnd_scan(30);
      step();
      cyc++;
    end
    chk("mid_writes", 32'(nw), 32'd1000);
    #3 reset = 1'b0;
    scan_req = 1'b0;
    #1 chk_all_zero("rst");
    @(negedge clk);
    nd = 0;
    step();
    step();
    reset = 1'b1;
    repeat (3) step();
    chk("rst_busy", 32'(clr_busy), 32'd0);
    chk("rst_no_done", 32'(nd), 32'd0);

    // A fresh clear restarts from address 0.
    clr_color = 12'h0A0; clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    chk("restart_busy", 32'(clr_busy), 32'd1);
    step();
    chk("restart_we", 32'(mem_we), 32'd1);
    chk("restart_addr", 32'(mem_addr), 32'd0);
    chk("restart_wdata", 32'(mem_wdata), 32'h0A0);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
